// File: rtl/isp_bnr_ctrl.sv
// isp_bnr_ctrl: frame-synchronous control and status unit for the Bayer
// noise-reduction stage.
//
// The host writes CTRL into a shadow copy. The shadow is applied to the BNR
// datapath only when vsync falls, so the datapath never sees a mid-frame change.
// The unit also watches in_href/in_vsync to count frames and to measure line
// width and line count. Geometry mismatches are flagged and an interrupt is
// raised.
//
// Ports
//   pclk, rst_n    clock, asynchronous active-low reset
//   in_href        line valid from the upstream stage
//   in_vsync       frame sync, active high
//   av_*           register bus: 0 CTRL, 1 STATUS, 2 FRAME_CNT, 3 GEOM
//   av_readdata    registered read data, valid the cycle after av_read
//   irq            level interrupt, irq_en & (sof | geom_err)
//   bnr_en         active enable to the datapath (0 = bypass)
//   bnr_bayer      active Bayer pattern to the datapath
//   frame_busy     high while a frame is being received
module isp_bnr_ctrl #(
   parameter int unsigned WIDTH     = 1280,
   parameter int unsigned HEIGHT    = 960,
   parameter int unsigned BAYER_DEF = 0,
   parameter int unsigned EN_DEF    = 1
) (
   input  logic        pclk,
   input  logic        rst_n,
   input  logic        in_href,
   input  logic        in_vsync,
   input  logic [1:0]  av_address,
   input  logic        av_write,
   input  logic [31:0] av_writedata,
   input  logic        av_read,
   output logic [31:0] av_readdata,
   output logic        irq,
   output logic        bnr_en,
   output logic [1:0]  bnr_bayer,
   output logic        frame_busy
);

   localparam logic [15:0] WidthC  = 16'(WIDTH);
   localparam logic [15:0] HeightC = 16'(HEIGHT);
   localparam logic        EnRst   = 1'(EN_DEF);
   localparam logic [1:0]  BayRst  = 2'(BAYER_DEF);

   typedef enum logic [1:0] {StSync, StVblank, StWait, StActive} state_t;

   state_t      state_q, state_d;
   logic        href_q;
   logic        pend_q, pend_d;
   logic        sh_en_q, sh_en_d;
   logic [1:0]  sh_bayer_q, sh_bayer_d;
   logic        irq_en_q, irq_en_d;
   logic        en_q, en_d;
   logic [1:0]  bayer_q, bayer_d;
   logic        sof_q, sof_d;
   logic        gerr_q, gerr_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [15:0] pix_cnt_q, pix_cnt_d;
   logic [15:0] line_cnt_q, line_cnt_d;
   logic [15:0] geom_w_q, geom_w_d;
   logic [15:0] geom_h_q, geom_h_d;
   logic [31:0] rdata_q, rdata_d;
   logic        irq_q, irq_d;

   logic        href_rise;
   logic        end_line;
   logic [15:0] line_fin;
   logic        sof_set, gerr_set, sof_clr, gerr_clr;
   logic        unused_wd;

   assign unused_wd = ^{av_writedata[31:10], av_writedata[7:3]};

   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      sh_en_d     = sh_en_q;
      sh_bayer_d  = sh_bayer_q;
      irq_en_d    = irq_en_q;
      en_d        = en_q;
      bayer_d     = bayer_q;
      frame_cnt_d = frame_cnt_q;
      pix_cnt_d   = pix_cnt_q;
      line_cnt_d  = line_cnt_q;
      geom_w_d    = geom_w_q;
      geom_h_d    = geom_h_q;
      rdata_d     = rdata_q;
      sof_set     = 1'b0;
      gerr_set    = 1'b0;
      sof_clr     = 1'b0;
      gerr_clr    = 1'b0;
      href_rise   = in_href & ~href_q;
      // A line ends on the href falling edge, or is cut short by vsync.
      end_line    = href_q & (~in_href | in_vsync);
      line_fin    = line_cnt_q;

      case (state_q)
         StSync: begin
            if (in_vsync) state_d = StVblank;
         end
         StVblank: begin
            if (!in_vsync) begin
               state_d = StWait;
               if (pend_q) begin
                  en_d    = sh_en_q;
                  bayer_d = sh_bayer_q;
                  pend_d  = 1'b0;
               end
            end
         end
         StWait: begin
            if (in_vsync) begin
               state_d = StVblank;
            end else if (href_rise) begin
               state_d     = StActive;
               frame_cnt_d = frame_cnt_q + 16'd1;
               sof_set     = 1'b1;
               line_cnt_d  = 16'd0;
               pix_cnt_d   = 16'd1;
            end
         end
         StActive: begin
            if (!in_vsync) begin
               // The rising cycle itself is the first pixel of the line.
               if (href_rise) begin
                  pix_cnt_d = 16'd1;
               end else if (in_href && pix_cnt_q != 16'hFFFF) begin
                  pix_cnt_d = pix_cnt_q + 16'd1;
               end
            end
            if (end_line && line_cnt_q != 16'hFFFF) line_fin = line_cnt_q + 16'd1;
            if (end_line) begin
               geom_w_d   = pix_cnt_q;
               line_cnt_d = line_fin;
               if (pix_cnt_q != WidthC) gerr_set = 1'b1;
            end
            if (in_vsync) begin
               state_d  = StVblank;
               geom_h_d = line_fin;
               if (line_fin != HeightC) gerr_set = 1'b1;
            end
         end
         default: state_d = StSync;
      endcase

      if (av_read) begin
         case (av_address)
            2'd0:    rdata_d = {23'd0, irq_en_q, 5'd0, sh_bayer_q, sh_en_q};
            2'd1:    rdata_d = {22'd0, gerr_q, sof_q, 6'd0, (state_q == StActive), pend_q};
            2'd2:    rdata_d = {16'd0, frame_cnt_q};
            default: rdata_d = {geom_h_q, geom_w_q};
         endcase
      end

      // Bus writes come last so a CTRL write on the apply cycle keeps pending set.
      if (av_write) begin
         case (av_address)
            2'd0: begin
               sh_en_d    = av_writedata[0];
               sh_bayer_d = av_writedata[2:1];
               irq_en_d   = av_writedata[8];
               pend_d     = 1'b1;
            end
            2'd1: begin
               sof_clr  = av_writedata[8];
               gerr_clr = av_writedata[9];
            end
            default: ;
         endcase
      end

      // Hardware set beats a simultaneous write-1-to-clear.
      sof_d  = (sof_q & ~sof_clr) | sof_set;
      gerr_d = (gerr_q & ~gerr_clr) | gerr_set;
      irq_d  = irq_en_q & (sof_q | gerr_q);
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StSync;
         href_q      <= 1'b0;
         pend_q      <= 1'b0;
         sh_en_q     <= EnRst;
         sh_bayer_q  <= BayRst;
         irq_en_q    <= 1'b0;
         en_q        <= EnRst;
         bayer_q     <= BayRst;
         sof_q       <= 1'b0;
         gerr_q      <= 1'b0;
         frame_cnt_q <= 16'd0;
         pix_cnt_q   <= 16'd0;
         line_cnt_q  <= 16'd0;
         geom_w_q    <= 16'd0;
         geom_h_q    <= 16'd0;
         rdata_q     <= 32'd0;
         irq_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         href_q      <= in_href;
         pend_q      <= pend_d;
         sh_en_q     <= sh_en_d;
         sh_bayer_q  <= sh_bayer_d;
         irq_en_q    <= irq_en_d;
         en_q        <= en_d;
         bayer_q     <= bayer_d;
         sof_q       <= sof_d;
         gerr_q      <= gerr_d;
         frame_cnt_q <= frame_cnt_d;
         pix_cnt_q   <= pix_cnt_d;
         line_cnt_q  <= line_cnt_d;
         geom_w_q    <= geom_w_d;
         geom_h_q    <= geom_h_d;
         rdata_q     <= rdata_d;
         irq_q       <= irq_d;
      end
   end

   assign av_readdata = rdata_q;
   assign irq         = irq_q;
   assign bnr_en      = en_q;
   assign bnr_bayer   = bayer_q;
   assign frame_busy  = (state_q == StActive);

endmodule
